// File: rtl/avalon_bcd_writer_pkg.sv
// Shared types and constants for the Avalon BCD digit writer.
package avalon_bcd_writer_pkg;

   localparam int         DIGIT_W      = 4;
   localparam int         AVM_ADDR_W   = 3;
   localparam int         AVM_DATA_W   = 32;
   localparam logic [3:0] AVM_BE_DIGIT = 4'b0001;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_WRITE   = 2'd2
   } state_e;

   // 10^n, used at elaboration time for the overflow limit
   function automatic logic [31:0] pow10(input int n);
      logic [31:0] p;
      p = 32'd1;
      for (int i = 0; i < n; i++) p = p * 32'd10;
      return p;
   endfunction

endpackage

// File: rtl/avalon_bcd_writer_if.sv
// Avalon-MM write-only master bus carrying one BCD digit per word.
interface avalon_bcd_writer_if;
   import avalon_bcd_writer_pkg::*;

   logic [AVM_ADDR_W-1:0] avm_address_o;
   logic [3:0]            avm_byteenable_o;
   logic                  avm_write_o;
   logic [AVM_DATA_W-1:0] avm_writedata_o;
   logic                  avm_waitrequest_i;

   modport master (
      output avm_address_o, avm_byteenable_o, avm_write_o, avm_writedata_o,
      input  avm_waitrequest_i
   );

   modport slave (
      input  avm_address_o, avm_byteenable_o, avm_write_o, avm_writedata_o,
      output avm_waitrequest_i
   );

endinterface

// File: rtl/bcd_double_dabble_seq.sv
// Sequential double-dabble: one input bit per cycle, DATA_W cycles after start.
module bcd_double_dabble_seq
   import avalon_bcd_writer_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int DATA_W     = 20
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [DATA_W-1:0]             value,
   output logic                          done,
   output logic [NUM_DIGITS*DIGIT_W-1:0] result,
   output logic                          overflow
);

   localparam int          BCD_W   = NUM_DIGITS * DIGIT_W;
   localparam int          CNT_W   = $clog2(DATA_W + 1);
   localparam logic [31:0] MAX_VAL = pow10(NUM_DIGITS) - 32'd1;

   logic [DATA_W-1:0] bin_q;
   logic [BCD_W-1:0]  bcd_q;
   logic [BCD_W-1:0]  bcd_step;
   logic [CNT_W-1:0]  cnt_q;
   logic              ovf_q;

   function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] bcd, input logic bit_in);
      logic [BCD_W-1:0] adj;
      adj = bcd;
      for (int d = 0; d < NUM_DIGITS; d++)
         if (adj[d*DIGIT_W +: DIGIT_W] >= 4'd5)
            adj[d*DIGIT_W +: DIGIT_W] = adj[d*DIGIT_W +: DIGIT_W] + 4'd3;
      return {adj[BCD_W-2:0], bit_in};
   endfunction

   assign bcd_step = dabble(bcd_q, bin_q[DATA_W-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              cnt_q <= '0;
      else if (start)          cnt_q <= CNT_W'(DATA_W);
      else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (start) begin
         bin_q <= value;
         bcd_q <= '0;
         ovf_q <= (32'(value) > MAX_VAL);
      end else if (cnt_q != '0) begin
         bin_q <= bin_q << 1;
         bcd_q <= bcd_step;
      end
   end

   // The final shift is exposed combinationally so the caller can act on the same edge
   assign done     = (cnt_q == CNT_W'(1));
   assign result   = bcd_step;
   assign overflow = ovf_q;

endmodule

// File: rtl/avalon_bcd_writer_de1soc.sv
// Converts a binary value to BCD and writes each digit over Avalon-MM, LSD first.
// Optional: AVALON_BCD_WRITER_SKIP_UNCHANGED_EN skips digits equal to their last written value.
module avalon_bcd_writer_de1soc
   import avalon_bcd_writer_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int DATA_W     = 20
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_W-1:0]          value_i,
   input  logic                       value_valid_i,
   output logic                       value_ready_o,
   avalon_bcd_writer_if.master        avm,
   output logic                       busy_o,
   output logic                       overflow_o
);

   typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

   state_e                  state_q, state_d;
   logic                    accept;
   logic                    conv_done;
   logic                    conv_ovf;
   digits_t                 conv_result;
   digits_t                 final_digits;
   digits_t                 digits_q;
   logic [NUM_DIGITS-1:0]   pend_q;
   logic [NUM_DIGITS-1:0]   pend_next;
   logic [NUM_DIGITS-1:0]   load_mask;
   logic [AVM_ADDR_W-1:0]   idx;
   logic [DIGIT_W-1:0]      digit_cur;
   logic                    wr_done;
   logic                    load;

   assign accept = value_valid_i && (state_q == ST_IDLE);

   bcd_double_dabble_seq #(
      .NUM_DIGITS (NUM_DIGITS),
      .DATA_W     (DATA_W)
   ) u_dabble (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (accept),
      .value    (value_i),
      .done     (conv_done),
      .result   (conv_result),
      .overflow (conv_ovf)
   );

   assign final_digits = conv_ovf ? {NUM_DIGITS{4'd9}} : conv_result;
   assign load         = (state_q == ST_CONVERT) && conv_done;

   // Lowest pending digit is the one on the bus
   always_comb begin
      idx       = '0;
      digit_cur = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            idx       = AVM_ADDR_W'(i);
            digit_cur = digits_q[i];
         end
      end
   end

   assign pend_next = pend_q & ~(NUM_DIGITS'(1) << idx);
   assign wr_done   = (state_q == ST_WRITE) && !avm.avm_waitrequest_i;

`ifdef AVALON_BCD_WRITER_SKIP_UNCHANGED_EN
   digits_t               shd_q;
   logic [NUM_DIGITS-1:0] shd_vld_q;
   logic [NUM_DIGITS-1:0] wr_sel;

   assign wr_sel = pend_q & ~pend_next;

   always_comb begin
      load_mask = '1;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (shd_vld_q[i] && (shd_q[i] == final_digits[i])) load_mask[i] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       shd_vld_q <= '0;
      else if (wr_done) shd_vld_q <= shd_vld_q | wr_sel;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_DIGITS; i++)
         if (wr_done && wr_sel[i]) shd_q[i] <= digit_cur;
   end
`else
   assign load_mask = '1;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (value_valid_i) state_d = ST_CONVERT;
         ST_CONVERT: if (conv_done) state_d = (load_mask == '0) ? ST_IDLE : ST_WRITE;
         ST_WRITE:   if (wr_done && (pend_next == '0)) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pend_q     <= '0;
         overflow_o <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            pend_q     <= load_mask;
            overflow_o <= conv_ovf;
         end else if (wr_done) begin
            pend_q <= pend_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load) digits_q <= final_digits;
   end

   // Bus outputs are forced to zero whenever no write is requested
   assign avm.avm_write_o      = (state_q == ST_WRITE);
   assign avm.avm_address_o    = avm.avm_write_o ? idx : '0;
   assign avm.avm_writedata_o  = avm.avm_write_o ? AVM_DATA_W'(digit_cur) : '0;
   assign avm.avm_byteenable_o = avm.avm_write_o ? AVM_BE_DIGIT : 4'b0000;

   assign value_ready_o = (state_q == ST_IDLE);
   assign busy_o        = !value_ready_o;

endmodule

// File: tb/tb_avalon_bcd_writer_de1soc.sv
// Randomized bench for avalon_bcd_writer_de1soc against a decimal-arithmetic reference model.
module tb_avalon_bcd_writer_de1soc;

   localparam int NUM_DIGITS = 6;
   localparam int DATA_W     = 20;
   localparam int LIMIT      = 1000000;

   logic              clk;
   logic              rst_n;
   logic [DATA_W-1:0] value_i;
   logic              value_valid_i;
   logic              value_ready_o;
   logic              busy_o;
   logic              overflow_o;

   avalon_bcd_writer_if avm_bus();

   avalon_bcd_writer_de1soc #(
      .NUM_DIGITS (NUM_DIGITS),
      .DATA_W     (DATA_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .value_i       (value_i),
      .value_valid_i (value_valid_i),
      .value_ready_o (value_ready_o),
      .avm           (avm_bus),
      .busy_o        (busy_o),
      .overflow_o    (overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Slave side: completed writes and stalled-cycle samples
   logic [63:0] wr_q[$];
   logic [63:0] held_q[$];
   int          stall_addr = 0;
   int          stall_left = 0;

   // Reference shadow of last written digit per address
   int sh_val[NUM_DIGITS];
   bit sh_vld[NUM_DIGITS];

   always @(negedge clk) begin
      if (stall_left > 0 && avm_bus.avm_write_o && (int'(avm_bus.avm_address_o) == stall_addr)) begin
         avm_bus.avm_waitrequest_i = 1'b1;
         stall_left = stall_left - 1;
         held_q.push_back({29'd0, avm_bus.avm_address_o, avm_bus.avm_writedata_o});
      end else begin
         avm_bus.avm_waitrequest_i = 1'b0;
      end
      if (rst_n && avm_bus.avm_write_o && !avm_bus.avm_waitrequest_i)
         wr_q.push_back({25'd0, avm_bus.avm_address_o, avm_bus.avm_byteenable_o,
                         avm_bus.avm_writedata_o});
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int dec_digit(input int unsigned v, input int k);
      int unsigned p;
      p = 1;
      for (int i = 0; i < k; i++) p = p * 10;
      return int'((v / p) % 10);
   endfunction

   function automatic logic [63:0] pack_wr(input int a, input int d);
      logic [2:0]  a3;
      logic [31:0] d32;
      a3  = a[2:0];
      d32 = d;
      return {25'd0, a3, 4'b0001, d32};
   endfunction

   task automatic run_seq(input int unsigned val, input int s_addr, input int s_cycles, input bit junk);
      int  exp_addr[$];
      int  exp_data[$];
      int  dig[NUM_DIGITS];
      bit  ovf;
      int  n;
      int  stalled;
      ovf = (val >= LIMIT);
      for (int k = 0; k < NUM_DIGITS; k++) begin
         dig[k] = ovf ? 9 : dec_digit(val, k);
`ifdef AVALON_BCD_WRITER_SKIP_UNCHANGED_EN
         if (!(sh_vld[k] && sh_val[k] == dig[k])) begin
            exp_addr.push_back(k);
            exp_data.push_back(dig[k]);
         end
`else
         exp_addr.push_back(k);
         exp_data.push_back(dig[k]);
`endif
      end
      stalled = 0;
      foreach (exp_addr[j]) if (exp_addr[j] == s_addr) stalled = s_cycles;

      wr_q.delete();
      held_q.delete();
      stall_addr    = s_addr;
      stall_left    = s_cycles;
      value_i       = val[DATA_W-1:0];
      value_valid_i = 1'b1;
      @(posedge clk);
      n = 1;
      #1;
      if (junk) value_i = 20'd555;
      else      value_valid_i = 1'b0;
      while (!value_ready_o && n < 200) begin
         @(posedge clk);
         n++;
         #1;
      end
      value_valid_i = 1'b0;
      stall_left    = 0;

      check_val("latency", n, 1 + DATA_W + exp_addr.size() + stalled);
      check_val("nwrites", wr_q.size(), exp_addr.size());
      for (int j = 0; j < exp_addr.size() && j < wr_q.size(); j++)
         check_val("write", wr_q[j], pack_wr(exp_addr[j], exp_data[j]));
      check_val("overflow", overflow_o, ovf);
      check_val("idle_bus", {avm_bus.avm_write_o, avm_bus.avm_address_o,
                             avm_bus.avm_byteenable_o, avm_bus.avm_writedata_o}, 64'd0);
      if (stalled > 0) begin
         check_val("held_n", held_q.size(), stalled);
         foreach (held_q[j])
            check_val("held", held_q[j], {29'd0, 3'(s_addr), 32'(dig[s_addr])});
      end
      foreach (exp_addr[j]) begin
         sh_val[exp_addr[j]] = exp_data[j];
         sh_vld[exp_addr[j]] = 1'b1;
      end
   endtask

   initial begin
      int          found;
      int unsigned v;
      rst_n         = 1'b0;
      value_i       = '0;
      value_valid_i = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin sh_vld[k] = 1'b0; sh_val[k] = 0; end
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_ready", {value_ready_o, busy_o, overflow_o}, 3'b100);
      check_val("rst_bus", {avm_bus.avm_write_o, avm_bus.avm_address_o,
                            avm_bus.avm_byteenable_o, avm_bus.avm_writedata_o}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset asserted while address 3 is on the bus
      wr_q.delete();
      value_i       = 20'd123456;
      value_valid_i = 1'b1;
      @(posedge clk);
      #1;
      value_valid_i = 1'b0;
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(posedge clk);
         #1;
         if (avm_bus.avm_write_o && avm_bus.avm_address_o == 3'd3) found = 1;
      end
      check_val("rst_found_addr3", found, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("rst_mid_ctrl", {avm_bus.avm_write_o, value_ready_o, busy_o, overflow_o}, 4'b0100);
      check_val("rst_mid_bus", {avm_bus.avm_address_o, avm_bus.avm_byteenable_o,
                                avm_bus.avm_writedata_o}, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) sh_vld[k] = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check_val("rst_nwrites", wr_q.size(), 3);
      for (int j = 0; j < 3 && j < wr_q.size(); j++)
         check_val("rst_write", wr_q[j], pack_wr(j, dec_digit(123456, j)));
      check_val("rst_after_ready", value_ready_o, 1'b1);

      run_seq(123456, 0, 0, 1'b0);
      run_seq(123457, 0, 0, 1'b0);
      run_seq(42, 2, 3, 1'b0);
      run_seq(1000000, 0, 0, 1'b0);
      run_seq(7, 0, 0, 1'b0);
      run_seq(314159, 0, 0, 1'b1);
      repeat (30) @(posedge clk);
      #1;
      check_val("junk_ignored_nwr", wr_q.size(), (NUM_DIGITS > 0) ? 6 : 0);
      check_val("junk_ready", value_ready_o, 1'b1);

      for (int it = 0; it < 12; it++) begin
         if ($urandom_range(0, 3) == 0) v = $urandom_range(999990, 1000010);
         else                           v = $urandom_range(0, 1048575);
         run_seq(v, $urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      run_seq(999999, 5, 2, 1'b0);
      run_seq(999999, 0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
